// File: rtl/td4_decode_if.sv
// td4_decode_if: bus between the TD4 decoder and the surrounding CPU.
//   slave  : decoder side. It takes in the PC address, the adder carry and the
//            programming port. It drives the counter LOAD, the immediate,
//            the ALU select, the load strobes, CF and HALTED.
//   master : CPU/datapath side. Every direction is the reverse of slave.
interface td4_decode_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IM_W   = 4
);
  logic [ADDR_W-1:0] ADDR;
  logic              ALU_CARRY;
  logic              PROG_EN;
  logic              PROG_WE;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic [4+IM_W-1:0] PROG_DATA;
  logic              PC_LOAD;
  logic [IM_W-1:0]   IM;
  logic [1:0]        SEL;
  logic              LD_A_N;
  logic              LD_B_N;
  logic              LD_OUT_N;
  logic              CF;
  logic              HALTED;

  modport slave (
    input  ADDR, ALU_CARRY, PROG_EN, PROG_WE, PROG_ADDR, PROG_DATA,
    output PC_LOAD, IM, SEL, LD_A_N, LD_B_N, LD_OUT_N, CF, HALTED
  );

  modport master (
    output ADDR, ALU_CARRY, PROG_EN, PROG_WE, PROG_ADDR, PROG_DATA,
    input  PC_LOAD, IM, SEL, LD_A_N, LD_B_N, LD_OUT_N, CF, HALTED
  );
endinterface

// File: rtl/td4_decode.sv
// td4_decode: TD4 program store, instruction decoder and carry flag.
//   CLK, RSTB : clock (rising edge) and async active-low reset
//   bus       : td4_decode_if.slave
//     ADDR        PC value. It is the asynchronous fetch address.
//     ALU_CARRY   adder carry-out. CF captures it at each RUN edge.
//     PROG_*      program-write port. It writes only while in PROG.
//     PC_LOAD     counter LOAD: 1 = increment, 0 = load IM
//     IM, SEL     immediate / jump target, and the ALU source select
//     LD_*_N      active-low load strobes for A, B and OUT
//     CF, HALTED  registered carry flag, and the HALT-state indicator
// Optional: define TD4_HALT_EN to turn opcode 1100 into HLT.
//   When TD4_HALT_EN is undefined, 1100 is a NOP and HALTED stays 0.
// Decode is combinational on ADDR. In PROG the outputs hold PC at 0.
module td4_decode #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IM_W   = 4
) (
  input  logic          CLK,
  input  logic          RSTB,
  td4_decode_if.slave   bus
);

  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = OP_W + IM_W;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_PROG = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] instr;
  logic [OP_W-1:0]    op;
  logic [IM_W-1:0]    imm;
  logic               cf;

  logic               pc_load;
  logic [IM_W-1:0]    im;
  logic [1:0]         sel;
  logic               ld_a_n;
  logic               ld_b_n;
  logic               ld_out_n;
  logic               halted;

  // Asynchronous fetch
  assign instr = mem[bus.ADDR];
  assign op    = instr[INSTR_W-1 -: OP_W];
  assign imm   = instr[IM_W-1:0];

  // State register
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= ST_PROG;
    else       state <= state_nxt;
  end

  // Program memory. It has no reset, so a reset keeps the loaded program.
  always_ff @(posedge CLK) begin
    if (state == ST_PROG && bus.PROG_WE) mem[bus.PROG_ADDR] <= bus.PROG_DATA;
  end

  // Carry flag. It is cleared in PROG, tracks the adder in RUN and holds in HALT.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      cf <= 1'b0;
    end else begin
      case (state)
        ST_RUN:  cf <= bus.ALU_CARRY;
        ST_PROG: cf <= 1'b0;
        default: cf <= cf;
      endcase
    end
  end

  // Next state and decode. The defaults are the PROG outputs, which force PC to 0.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    im        = '0;
    sel       = 2'b11;
    ld_a_n    = 1'b1;
    ld_b_n    = 1'b1;
    ld_out_n  = 1'b1;
    halted    = 1'b0;
    case (state)
      ST_PROG: begin
        if (!bus.PROG_EN) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.PROG_EN) state_nxt = ST_PROG;
        pc_load = 1'b1;
        im      = imm;
        case (op)
          4'b0000: begin sel = 2'b00; ld_a_n   = 1'b0; end
          4'b0101: begin sel = 2'b01; ld_b_n   = 1'b0; end
          4'b0011: begin sel = 2'b11; ld_a_n   = 1'b0; end
          4'b0111: begin sel = 2'b11; ld_b_n   = 1'b0; end
          4'b0001: begin sel = 2'b01; ld_a_n   = 1'b0; end
          4'b0100: begin sel = 2'b00; ld_b_n   = 1'b0; end
          4'b0010: begin sel = 2'b10; ld_a_n   = 1'b0; end
          4'b0110: begin sel = 2'b10; ld_b_n   = 1'b0; end
          4'b1001: begin sel = 2'b01; ld_out_n = 1'b0; end
          4'b1011: begin sel = 2'b11; ld_out_n = 1'b0; end
          4'b1111: pc_load = 1'b0;
          // JNC: jump only when the previous instruction produced no carry
          4'b1110: pc_load = cf;
`ifdef TD4_HALT_EN
          // HLT: PC reloads its own address. PROG_EN takes priority over HALT.
          4'b1100: begin
            pc_load = 1'b0;
            im      = IM_W'(bus.ADDR);
            if (!bus.PROG_EN) state_nxt = ST_HALT;
          end
`endif
          default: ;
        endcase
      end
      ST_HALT: begin
`ifdef TD4_HALT_EN
        if (bus.PROG_EN) state_nxt = ST_PROG;
        im     = IM_W'(bus.ADDR);
        halted = 1'b1;
`else
        state_nxt = ST_PROG;
`endif
      end
      default: state_nxt = ST_PROG;
    endcase
  end

  assign bus.PC_LOAD  = pc_load;
  assign bus.IM       = im;
  assign bus.SEL      = sel;
  assign bus.LD_A_N   = ld_a_n;
  assign bus.LD_B_N   = ld_b_n;
  assign bus.LD_OUT_N = ld_out_n;
  assign bus.CF       = cf;
  assign bus.HALTED   = halted;

endmodule

// File: tb/tb_td4_decode.sv
// tb_td4_decode: directed test of td4_decode with hand-computed decode vectors.
// The bench plays the PC by driving ADDR directly.
module tb_td4_decode;

  logic clk;
  logic rstb;
  int   checks;
  int   errors;

  td4_decode_if #(.ADDR_W(4), .IM_W(4)) bus ();

  td4_decode #(.ADDR_W(4), .IM_W(4)) u_dut (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_LOAD, IM[3:0], SEL[1:0], LD_A_N, LD_B_N, LD_OUT_N}
  logic [9:0] dec_v;
  assign dec_v = {bus.PC_LOAD, bus.IM, bus.SEL, bus.LD_A_N, bus.LD_B_N, bus.LD_OUT_N};

  localparam logic [9:0] PROG_V = 10'b0_0000_11_111;

  localparam logic [7:0] PROGRAM [16] = '{
    8'h35, 8'h00, 8'hF9, 8'hC0, 8'hE4, 8'h52, 8'h7A, 8'h1F,
    8'h43, 8'h27, 8'h61, 8'h98, 8'hBC, 8'h86, 8'hA1, 8'hDE
  };

  // Expected RUN decode with CF=0. Entry 3 is the NOP form of 0xC0.
  localparam logic [9:0] EXP [16] = '{
    10'b1_0101_11_011,  // 35 MOV A,5
    10'b1_0000_00_011,  // 00 ADD A,0
    10'b0_1001_11_111,  // F9 JMP 9
    10'b1_0000_11_111,  // C0 NOP
    10'b0_0100_11_111,  // E4 JNC 4, CF=0 -> jump
    10'b1_0010_01_101,  // 52 ADD B,2
    10'b1_1010_11_101,  // 7A MOV B,A(imm)
    10'b1_1111_01_011,  // 1F MOV A,B
    10'b1_0011_00_101,  // 43 MOV B,A
    10'b1_0111_10_011,  // 27 IN A
    10'b1_0001_10_101,  // 61 IN B
    10'b1_1000_01_110,  // 98 OUT B
    10'b1_1100_11_110,  // BC OUT Im
    10'b1_0110_11_111,  // 86 NOP
    10'b1_0001_11_111,  // A1 NOP
    10'b1_1110_11_111   // DE NOP
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstb          = 1'b0;
    bus.ADDR      = '0;
    bus.ALU_CARRY = 1'b0;
    bus.PROG_EN   = 1'b1;
    bus.PROG_WE   = 1'b0;
    bus.PROG_ADDR = '0;
    bus.PROG_DATA = '0;

    #12;
    check("rst_dec", 32'(dec_v), 32'(PROG_V));
    check("rst_cf", 32'(bus.CF), 32'd0);
    check("rst_halted", 32'(bus.HALTED), 32'd0);
    rstb = 1'b1;

    // Load the program. The outputs stay forced to PROG values throughout.
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      bus.PROG_WE   = 1'b1;
      bus.PROG_ADDR = a[3:0];
      bus.PROG_DATA = PROGRAM[a];
      bus.ADDR      = a[3:0];
      bus.ALU_CARRY = 1'b1;
      #1 check($sformatf("prog_dec_%0d", a), 32'(dec_v), 32'(PROG_V));
    end
    @(negedge clk);
    check("prog_cf_hold", 32'(bus.CF), 32'd0);
    bus.PROG_WE = 1'b0;
    bus.PROG_EN = 1'b0;
    bus.ADDR    = 4'd0;
    #1 check("prog_last_cycle", 32'(dec_v), 32'(PROG_V));

    // RUN: decode every stored word (CF stays 0)
    @(negedge clk);
    bus.ALU_CARRY = 1'b0;
    #1 check("run_cf_start", 32'(bus.CF), 32'd0);
    for (int a = 0; a < 16; a++) begin
      if (a != 3) begin
        bus.ADDR = a[3:0];
        #1 check($sformatf("dec_%0d", a), 32'(dec_v), 32'(EXP[a]));
        @(negedge clk);
      end
    end

    // JNC with a carry from the previous instruction, then without one
    bus.ADDR      = 4'd1;
    bus.ALU_CARRY = 1'b1;
    @(negedge clk);
    bus.ALU_CARRY = 1'b0;
    bus.ADDR      = 4'd4;
    #1 check("jnc_cf1_cf", 32'(bus.CF), 32'd1);
    check("jnc_cf1_dec", 32'(dec_v), 32'(10'b1_0100_11_111));
    @(negedge clk);
    #1 check("jnc_cf0_cf", 32'(bus.CF), 32'd0);
    check("jnc_cf0_dec", 32'(dec_v), 32'(EXP[4]));

    // PROG_WE is ignored in RUN
    @(negedge clk);
    bus.ADDR      = 4'd13;
    bus.PROG_WE   = 1'b1;
    bus.PROG_ADDR = 4'd0;
    bus.PROG_DATA = 8'hFF;
    @(negedge clk);
    bus.PROG_WE = 1'b0;

    // PROG_EN together with a JMP: this cycle's decode is unchanged, PROG follows
    bus.PROG_EN = 1'b1;
    bus.ADDR    = 4'd2;
    #1 check("jmp_progen_dec", 32'(dec_v), 32'(EXP[2]));
    @(negedge clk);
    #1 check("reprog_dec", 32'(dec_v), 32'(PROG_V));
    bus.PROG_EN = 1'b0;
    @(negedge clk);
    bus.ADDR = 4'd0;
    #1 check("we_ignored_mem0", 32'(dec_v), 32'(EXP[0]));

    // Async reset mid-RUN with CF=1
    @(negedge clk);
    bus.ADDR      = 4'd1;
    bus.ALU_CARRY = 1'b1;
    @(negedge clk);
    bus.ALU_CARRY = 1'b0;
    #1 check("pre_rst_cf", 32'(bus.CF), 32'd1);
    #1 rstb = 1'b0;
    #1 check("async_rst_cf", 32'(bus.CF), 32'd0);
    check("async_rst_dec", 32'(dec_v), 32'(PROG_V));
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    bus.ADDR = 4'd0;
    #1 check("post_rst_mem0", 32'(dec_v), 32'(EXP[0]));
    @(negedge clk);
    bus.ADDR = 4'd5;
    #1 check("post_rst_mem5", 32'(dec_v), 32'(EXP[5]));

    // Opcode 1100 at address 3
    @(negedge clk);
    bus.ADDR = 4'd3;
`ifdef TD4_HALT_EN
    #1 check("hlt_dec", 32'(dec_v), 32'(10'b0_0011_11_111));
    check("hlt_halted_pre", 32'(bus.HALTED), 32'd0);
    @(negedge clk);
    bus.ALU_CARRY = 1'b1;
    #1 check("halt_halted", 32'(bus.HALTED), 32'd1);
    check("halt_dec", 32'(dec_v), 32'(10'b0_0011_11_111));
    @(negedge clk);
    bus.ADDR = 4'd7;
    #1 check("halt_im_addr", 32'(dec_v), 32'(10'b0_0111_11_111));
    check("halt_cf_held", 32'(bus.CF), 32'd0);
    check("halt_stays", 32'(bus.HALTED), 32'd1);
    bus.PROG_EN = 1'b1;
    @(negedge clk);
    #1 check("halt_exit", 32'(bus.HALTED), 32'd0);
    check("halt_exit_dec", 32'(dec_v), 32'(PROG_V));
`else
    #1 check("nop1100_dec", 32'(dec_v), 32'(EXP[3]));
    check("nop1100_halted", 32'(bus.HALTED), 32'd0);
    @(negedge clk);
    #1 check("nop1100_next_dec", 32'(dec_v), 32'(EXP[3]));
    check("nop1100_next_halted", 32'(bus.HALTED), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_decode.md
Name: td4_decode

Overview:
- Instruction store, decoder and carry-flag stage of the TD4 CPU.
- Sits directly downstream of the 4-bit program counter: takes the PC value as its fetch address.
- Drives the counter's LOAD input (1 = increment, 0 = load IN), the immediate value, the ALU source select and the active-low register load strobes.
- Also holds the 16x8 program memory, written through a programming port while the CPU is parked.

Parameters:
- ADDR_W, 4, PC/program-memory address width; depth = 2**ADDR_W.
- IM_W, 4, immediate and datapath width; instruction word = 4-bit opcode + IM_W.

Ports:
- CLK  input  1  clock, rising edge.
- RSTB  input  1  asynchronous, active-low reset.
- ADDR  input  ADDR_W  current PC value.
- ALU_CARRY  input  1  carry out of the datapath adder, this cycle.
- PROG_EN  input  1  1 = park CPU and allow program writes.
- PROG_WE  input  1  program write strobe, honoured only in PROG.
- PROG_ADDR  input  ADDR_W  program write address.
- PROG_DATA  input  4+IM_W  program write data {opcode, imm}.
- PC_LOAD  output  1  to counter LOAD: 1 = increment, 0 = load IM.
- IM  output  IM_W  immediate field / jump target.
- SEL  output  2  ALU source: 00 reg A, 01 reg B, 10 input port, 11 zero.
- LD_A_N, LD_B_N, LD_OUT_N  output  1 each  active-low load strobes for A, B and output port.
- CF  output  1  registered carry flag.
- HALTED  output  1  1 while in HALT state.

Behaviour:
- State register values: PROG, RUN, HALT.
  - Async reset → PROG.
  - PROG → RUN at the first edge with PROG_EN=0.
  - RUN → PROG at any edge with PROG_EN=1.
  - HALT → PROG at any edge with PROG_EN=1.
  - Reset mid-operation: immediate return to PROG, CF=0. Memory contents are retained (memory is not reset).
- PROG state:
  - Outputs: PC_LOAD=0, IM=0, SEL=11, all LD_*_N=1, HALTED=0. This forces the PC to 0 every cycle, so RUN always begins at address 0.
  - Write: mem[PROG_ADDR] <= PROG_DATA at the edge when PROG_WE=1.
  - PROG_WE in RUN or HALT is ignored.
  - CF held at 0.
- Reset values of outputs are the PROG values above, plus CF=0.
- RUN fetch and decode:
  - Fetch is asynchronous: INSTR = mem[ADDR], op = INSTR[7:4], IM = INSTR[3:0].
  - Zero latency: decode and strobes are combinational on ADDR within the same cycle. The target register captures at the next edge.
  - Defaults: PC_LOAD=1, LD_*_N=1.
- Decode table (op: SEL, strobe):
  - 0000 ADD A,Im: 00, LD_A_N=0.
  - 0101 ADD B,Im: 01, LD_B_N=0.
  - 0011 MOV A,Im: 11, LD_A_N=0.
  - 0111 MOV B,Im: 11, LD_B_N=0.
  - 0001 MOV A,B: 01, LD_A_N=0.
  - 0100 MOV B,A: 00, LD_B_N=0.
  - 0010 IN A: 10, LD_A_N=0.
  - 0110 IN B: 10, LD_B_N=0.
  - 1001 OUT B: 01, LD_OUT_N=0.
  - 1011 OUT Im: 11, LD_OUT_N=0.
  - 1111 JMP Im: 11, PC_LOAD=0.
  - 1110 JNC Im: 11, PC_LOAD=CF (jump only when CF=0).
  - Others (1000, 1010, 1100, 1101): NOP, SEL=11, no strobes, PC_LOAD=1.
- CF <= ALU_CARRY at every RUN edge, including jumps and NOPs. JNC therefore tests the carry of the previous instruction.
- Address wrap: incrementing from 15 to 0 is the counter's job. The decoder imposes no boundary.
- Simultaneous PROG_EN=1 and a jump in RUN: the state change wins. The PROG outputs take effect from the next cycle; the current cycle's decode is unaffected.

Optional Feature:
- TD4_HALT_EN defined: opcode 1100 is HLT.
  - In RUN, HLT drives PC_LOAD=0 and IM=ADDR so the PC reloads its own address, with no strobes. The state moves to HALT at that edge.
  - In HALT: PC_LOAD=0, IM=ADDR, SEL=11, no strobes, HALTED=1, CF held.
  - Exit is only via PROG_EN=1 or reset.
- TD4_HALT_EN undefined: 1100 is a NOP, the HALT state is unreachable and HALTED is tied to 0.

Test Plan:
- Reset, PROG_EN=1, write mem[0]=0x35, mem[1]=0x00, drop PROG_EN → in PROG cycle PC_LOAD=0/IM=0; at ADDR=0 SEL=11, LD_A_N=0, IM=5, PC_LOAD=1.
- RUN, ADDR→mem=0xF9 (JMP 9) → PC_LOAD=0, IM=9, SEL=11, all LD_*_N=1.
- ALU_CARRY=1 on one cycle, next instr 0xE4 (JNC 4) → CF=1, PC_LOAD=1; repeat with ALU_CARRY=0 → PC_LOAD=0, IM=4.
- RUN with PROG_WE=1, PROG_ADDR=0, PROG_DATA=0xFF → mem[0] unchanged on readback after re-entering PROG.
- Assert RSTB=0 mid-RUN with CF=1 → CF=0 and PC_LOAD=0 immediately (async); memory contents intact after release.
- TD4_HALT_EN: mem[3]=0xC0 at ADDR=3 → PC_LOAD=0, IM=3, HALTED=1 next cycle; stays until PROG_EN=1, then HALTED=0. Without the macro the same word gives PC_LOAD=1, HALTED=0.
